// File: rtl/ddr_port_arbiter_if.sv
// Client-side and controller-side signal bundle of the DDR user-port arbiter.
// The slave modport is the arbiter; the master modport drives clients and controller.
interface ddr_port_arbiter_if #(
    parameter int OWNERS = 2,
    parameter int UADDR  = 23,
    parameter int UWIDTH = 32,
    parameter int UBYTES = 4
);
    localparam int N = 2**OWNERS;

    logic [N-1:0]        c_rd_req_i;
    logic [N-1:0]        c_rd_block_i;
    logic [N*UADDR-1:0]  c_rd_addr_i;
    logic [N-1:0]        c_rd_ack_o;
    logic [N-1:0]        c_rd_ready_o;
    logic [UWIDTH-1:0]   c_rd_data_o;
    logic [N-1:0]        c_wr_req_i;
    logic [N*UADDR-1:0]  c_wr_addr_i;
    logic [N*UBYTES-1:0] c_wr_bes_ni;
    logic [N*UWIDTH-1:0] c_wr_data_i;
    logic [N-1:0]        c_wr_ack_o;

    logic                rd_req_o;
    logic                rd_block_o;
    logic [OWNERS-1:0]   rd_owner_o;
    logic [UADDR-1:0]    rd_addr_o;
    logic                rd_busy_i;
    logic [OWNERS-1:0]   rd_owner_i;
    logic [UWIDTH-1:0]   rd_data_i;
    logic                rd_ready_i;
    logic                wr_req_o;
    logic [UADDR-1:0]    wr_addr_o;
    logic [UBYTES-1:0]   wr_bes_no;
    logic [UWIDTH-1:0]   wr_data_o;
    logic                wr_busy_i;
    logic                err_o;

    modport slave (
        input  c_rd_req_i, c_rd_block_i, c_rd_addr_i,
        output c_rd_ack_o, c_rd_ready_o, c_rd_data_o,
        input  c_wr_req_i, c_wr_addr_i, c_wr_bes_ni, c_wr_data_i,
        output c_wr_ack_o,
        output rd_req_o, rd_block_o, rd_owner_o, rd_addr_o,
        input  rd_busy_i, rd_owner_i, rd_data_i, rd_ready_i,
        output wr_req_o, wr_addr_o, wr_bes_no, wr_data_o,
        input  wr_busy_i,
        output err_o
    );

    modport master (
        output c_rd_req_i, c_rd_block_i, c_rd_addr_i,
        input  c_rd_ack_o, c_rd_ready_o, c_rd_data_o,
        output c_wr_req_i, c_wr_addr_i, c_wr_bes_ni, c_wr_data_i,
        input  c_wr_ack_o,
        input  rd_req_o, rd_block_o, rd_owner_o, rd_addr_o,
        output rd_busy_i, rd_owner_i, rd_data_i, rd_ready_i,
        input  wr_req_o, wr_addr_o, wr_bes_no, wr_data_o,
        output wr_busy_i,
        input  err_o
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin sharing of the DDR user port among 2**OWNERS clients; one outstanding read per client.
// Issue and return both take one cycle; controller busy stalls only its own side, requests stay held.
module ddr_port_arbiter #(
    parameter int OWNERS      = 2,
    parameter int UADDR       = 23,
    parameter int UWIDTH      = 32,
    parameter int UBYTES      = 4,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                clock_i,
    input  logic                reset_i,
    ddr_port_arbiter_if.slave   bus
);
    localparam int N  = 2**OWNERS;
    localparam int CW = $clog2(BLOCK_WORDS + 1);

    logic [OWNERS-1:0] rdptr;
    logic [OWNERS-1:0] wrptr;
    logic [N-1:0]      pend;
    logic [CW-1:0]     cnt [N];

    logic [N-1:0]      rd_elig;
    logic [N-1:0]      wr_elig;
    logic              rd_hit;
    logic              wr_hit;
    logic [OWNERS-1:0] rd_g;
    logic [OWNERS-1:0] wr_g;
    logic              rd_go;
    logic              wr_go;

    // Scan downward so the nearest client after the pointer is the last to assign.
    function automatic logic [OWNERS:0] rr_pick(input logic [N-1:0] elig,
                                                input logic [OWNERS-1:0] ptr);
        logic [OWNERS:0]   r;
        logic [OWNERS-1:0] idx;
        r = '0;
        for (int k = N; k >= 1; k--) begin
            idx = ptr + OWNERS'(k);
            if (elig[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        rd_elig = bus.c_rd_req_i & ~pend & ~bus.c_rd_ack_o;
        wr_elig = bus.c_wr_req_i & ~bus.c_wr_ack_o;
        {rd_hit, rd_g} = rr_pick(rd_elig, rdptr);
        {wr_hit, wr_g} = rr_pick(wr_elig, wrptr);
        rd_go = rd_hit && !bus.rd_busy_i;
        wr_go = wr_hit && !bus.wr_busy_i;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bus.rd_req_o     <= 1'b0;
            bus.rd_block_o   <= 1'b0;
            bus.rd_owner_o   <= '0;
            bus.rd_addr_o    <= '0;
            bus.c_rd_ack_o   <= '0;
            bus.c_rd_ready_o <= '0;
            bus.c_rd_data_o  <= '0;
            bus.wr_req_o     <= 1'b0;
            bus.wr_addr_o    <= '0;
            bus.wr_bes_no    <= '0;
            bus.wr_data_o    <= '0;
            bus.c_wr_ack_o   <= '0;
            bus.err_o        <= 1'b0;
            rdptr            <= '1;
            wrptr            <= '1;
            pend             <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            bus.rd_req_o     <= rd_go;
            bus.c_rd_ack_o   <= '0;
            bus.c_rd_ready_o <= '0;
            bus.wr_req_o     <= wr_go;
            bus.c_wr_ack_o   <= '0;

            // A pending client is never eligible, so return and issue never share an index.
            if (bus.rd_ready_i) begin
                bus.c_rd_ready_o[bus.rd_owner_i] <= 1'b1;
                bus.c_rd_data_o                  <= bus.rd_data_i;
                if (pend[bus.rd_owner_i]) begin
                    cnt[bus.rd_owner_i] <= cnt[bus.rd_owner_i] - CW'(1);
                    if (cnt[bus.rd_owner_i] == CW'(1)) pend[bus.rd_owner_i] <= 1'b0;
                end else begin
                    bus.err_o <= 1'b1;
                end
            end

            if (rd_go) begin
                bus.rd_addr_o    <= bus.c_rd_addr_i[rd_g*UADDR +: UADDR];
                bus.rd_block_o   <= bus.c_rd_block_i[rd_g];
                bus.rd_owner_o   <= rd_g;
                bus.c_rd_ack_o[rd_g] <= 1'b1;
                rdptr            <= rd_g;
                pend[rd_g]       <= 1'b1;
                cnt[rd_g]        <= bus.c_rd_block_i[rd_g] ? CW'(BLOCK_WORDS) : CW'(1);
            end

            if (wr_go) begin
                bus.wr_addr_o    <= bus.c_wr_addr_i[wr_g*UADDR +: UADDR];
                bus.wr_bes_no    <= bus.c_wr_bes_ni[wr_g*UBYTES +: UBYTES];
                bus.wr_data_o    <= bus.c_wr_data_i[wr_g*UWIDTH +: UWIDTH];
                bus.c_wr_ack_o[wr_g] <= 1'b1;
                wrptr            <= wr_g;
            end
        end
    end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed table-driven bench for ddr_port_arbiter plus hand sequences for
// round-robin, block read and asynchronous reset.
module tb_ddr_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_port_arbiter_if #(.OWNERS(2), .UADDR(23), .UWIDTH(32), .UBYTES(4)) bus ();

    ddr_port_arbiter #(.OWNERS(2), .UADDR(23), .UWIDTH(32), .UBYTES(4), .BLOCK_WORDS(256)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [3:0]  rreq, rblk, wreq;
        logic        rbusy, wbusy, rrdy;
        logic [1:0]  rown;
        logic [31:0] rdat;
        logic [3:0]  e_rack;
        logic [1:0]  e_rown;
        logic [3:0]  e_rrdy;
        logic [3:0]  e_wack;
        logic        e_err;
    } vec_t;

    vec_t        vecs [20];
    logic [22:0] raddr [4];
    logic [22:0] waddr [4];
    logic [31:0] wdat  [4];
    logic [3:0]  wbes  [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t mk(input logic [3:0] rreq, input logic [3:0] rblk, input logic [3:0] wreq,
                                input logic rbusy, input logic wbusy, input logic rrdy,
                                input logic [1:0] rown, input logic [31:0] rdat,
                                input logic [3:0] e_rack, input logic [1:0] e_rown,
                                input logic [3:0] e_rrdy, input logic [3:0] e_wack, input logic e_err);
        vec_t v;
        v.rreq = rreq; v.rblk = rblk; v.wreq = wreq;
        v.rbusy = rbusy; v.wbusy = wbusy; v.rrdy = rrdy; v.rown = rown; v.rdat = rdat;
        v.e_rack = e_rack; v.e_rown = e_rown; v.e_rrdy = e_rrdy; v.e_wack = e_wack; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.c_rd_req_i   = '0;
        bus.c_rd_block_i = '0;
        bus.c_wr_req_i   = '0;
        bus.rd_busy_i    = 1'b0;
        bus.wr_busy_i    = 1'b0;
        bus.rd_ready_i   = 1'b0;
        bus.rd_owner_i   = '0;
        bus.rd_data_i    = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " rd_side"}, 64'({bus.rd_req_o, bus.rd_block_o, bus.rd_owner_o, bus.rd_addr_o,
                                   bus.c_rd_ack_o, bus.c_rd_ready_o}), 64'd0);
        chk({nm, " rd_data"}, 64'(bus.c_rd_data_o), 64'd0);
        chk({nm, " wr_side"}, 64'({bus.wr_req_o, bus.wr_addr_o, bus.wr_bes_no, bus.c_wr_ack_o, bus.err_o}), 64'd0);
        chk({nm, " wr_data"}, 64'(bus.wr_data_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            raddr[i] = 23'h001034 + 23'(i * 'h100);
            waddr[i] = 23'h002000 + 23'(i);
        end
        wdat[0] = 32'h11111111; wdat[1] = 32'h22222222; wdat[2] = 32'h2B2B2B2B; wdat[3] = 32'h33333333;
        wbes[0] = 4'b0000;      wbes[1] = 4'b0101;      wbes[2] = 4'b1010;      wbes[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.c_rd_addr_i[i*23 +: 23] = raddr[i];
            bus.c_wr_addr_i[i*23 +: 23] = waddr[i];
            bus.c_wr_data_i[i*32 +: 32] = wdat[i];
            bus.c_wr_bes_ni[i*4 +: 4]   = wbes[i];
        end

        //            rreq     rblk     wreq     rb wb rr own data           e_rack   own e_rrdy   e_wack   err
        vecs[0]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b0100, 2, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b0000, 2, 4'b0000, 4'b0000, 0);
        vecs[2]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 2, 32'hDEADBEEF,  4'b0000, 2, 4'b0100, 4'b0000, 0);
        vecs[3]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b0100, 2, 4'b0000, 4'b0000, 0);
        vecs[4]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b0000, 2, 4'b0000, 4'b0000, 0);
        vecs[5]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 2, 32'h0BADF00D,  4'b0000, 2, 4'b0100, 4'b0000, 0);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'h0,      4'b0000, 2, 4'b0000, 4'b0000, 0);
        vecs[11] = mk(4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b1000, 3, 4'b0000, 4'b0000, 0);
        vecs[12] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 3, 32'h12345678,  4'b0000, 3, 4'b1000, 4'b0000, 0);
        vecs[13] = mk(4'b0000, 4'b0000, 4'b1001, 0, 1, 0, 0, 32'h0,         4'b0000, 3, 4'b0000, 4'b0000, 0);
        vecs[14] = mk(4'b0000, 4'b0000, 4'b1001, 0, 1, 0, 0, 32'h0,         4'b0000, 3, 4'b0000, 4'b0000, 0);
        vecs[15] = mk(4'b0000, 4'b0000, 4'b1001, 0, 0, 0, 0, 32'h0,         4'b0000, 3, 4'b0000, 4'b0001, 0);
        vecs[16] = mk(4'b0000, 4'b0000, 4'b1001, 0, 0, 0, 0, 32'h0,         4'b0000, 3, 4'b0000, 4'b1000, 0);
        vecs[17] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b0000, 3, 4'b0000, 4'b0000, 0);
        vecs[18] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 1, 32'hCAFEF00D,  4'b0000, 3, 4'b0010, 4'b0000, 1);
        vecs[19] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,         4'b0000, 3, 4'b0000, 4'b0000, 1);

        idle_inputs();
        rst = 1'b1;
        #12;
        chk_all_zero("reset");
        step();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            int wi;
            bus.c_rd_req_i   = vecs[i].rreq;
            bus.c_rd_block_i = vecs[i].rblk;
            bus.c_wr_req_i   = vecs[i].wreq;
            bus.rd_busy_i    = vecs[i].rbusy;
            bus.wr_busy_i    = vecs[i].wbusy;
            bus.rd_ready_i   = vecs[i].rrdy;
            bus.rd_owner_i   = vecs[i].rown;
            bus.rd_data_i    = vecs[i].rdat;
            step();
            chk($sformatf("v%0d rd_req", i),   64'(bus.rd_req_o),     64'(|vecs[i].e_rack));
            chk($sformatf("v%0d rd_ack", i),   64'(bus.c_rd_ack_o),   64'(vecs[i].e_rack));
            chk($sformatf("v%0d rd_owner", i), 64'(bus.rd_owner_o),   64'(vecs[i].e_rown));
            if (|vecs[i].e_rack)
                chk($sformatf("v%0d rd_addr", i), 64'(bus.rd_addr_o), 64'(raddr[vecs[i].e_rown]));
            chk($sformatf("v%0d rd_ready", i), 64'(bus.c_rd_ready_o), 64'(vecs[i].e_rrdy));
            if (|vecs[i].e_rrdy)
                chk($sformatf("v%0d rd_data", i), 64'(bus.c_rd_data_o), 64'(vecs[i].rdat));
            chk($sformatf("v%0d wr_req", i),   64'(bus.wr_req_o),     64'(|vecs[i].e_wack));
            chk($sformatf("v%0d wr_ack", i),   64'(bus.c_wr_ack_o),   64'(vecs[i].e_wack));
            if (|vecs[i].e_wack) begin
                wi = 0;
                for (int k = 0; k < 4; k++) if (vecs[i].e_wack[k]) wi = k;
                chk($sformatf("v%0d wr_addr", i), 64'(bus.wr_addr_o), 64'(waddr[wi]));
                chk($sformatf("v%0d wr_data", i), 64'(bus.wr_data_o), 64'(wdat[wi]));
                chk($sformatf("v%0d wr_bes", i),  64'(bus.wr_bes_no), 64'(wbes[wi]));
            end
            chk($sformatf("v%0d err", i),      64'(bus.err_o),        64'(vecs[i].e_err));
        end

        // Round-robin from reset, then client 0 re-requests while its read is outstanding.
        do_reset();
        bus.c_rd_req_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr grant%0d ack", k),   64'(bus.c_rd_ack_o), 64'(4'b0001 << k));
            chk($sformatf("rr grant%0d owner", k), 64'(bus.rd_owner_o), 64'(k));
        end
        bus.c_rd_req_i = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("rr held%0d rd_req", k), 64'(bus.rd_req_o), 64'd0);
        end
        bus.rd_ready_i = 1'b1; bus.rd_owner_i = 2'd0; bus.rd_data_i = 32'hA0A0A0A0;
        step();
        chk("rr ret0 ready", 64'(bus.c_rd_ready_o), 64'(4'b0001));
        chk("rr ret0 rd_req", 64'(bus.rd_req_o), 64'd0);
        bus.rd_owner_i = 2'd1; bus.rd_data_i = 32'hA1A1A1A1;
        step();
        chk("rr regrant0 ack", 64'(bus.c_rd_ack_o), 64'(4'b0001));
        chk("rr ret1 ready", 64'(bus.c_rd_ready_o), 64'(4'b0010));
        chk("rr ret1 data", 64'(bus.c_rd_data_o), 64'h0000_0000_A1A1A1A1);
        chk("rr err", 64'(bus.err_o), 64'd0);

        // Block read: the re-request stays blocked for all 256 words.
        do_reset();
        bus.c_rd_req_i = 4'b0010; bus.c_rd_block_i = 4'b0010;
        step();
        chk("blk ack", 64'(bus.c_rd_ack_o), 64'(4'b0010));
        chk("blk block", 64'(bus.rd_block_o), 64'd1);
        chk("blk owner", 64'(bus.rd_owner_o), 64'd1);
        bus.rd_ready_i = 1'b1; bus.rd_owner_i = 2'd1;
        for (int w = 0; w < 256; w++) begin
            bus.rd_data_i = 32'(w) + 32'h5000;
            step();
            chk($sformatf("blk w%0d ready", w), 64'(bus.c_rd_ready_o), 64'(4'b0010));
            chk($sformatf("blk w%0d data", w),  64'(bus.c_rd_data_o),  64'(32'(w) + 32'h5000));
            chk($sformatf("blk w%0d rd_req", w), 64'(bus.rd_req_o), 64'd0);
        end
        bus.rd_ready_i = 1'b0;
        step();
        chk("blk regrant ack", 64'(bus.c_rd_ack_o), 64'(4'b0010));
        chk("blk err", 64'(bus.err_o), 64'd0);

        // Asynchronous reset in the middle of the second block read.
        bus.c_rd_req_i = 4'b0000;
        bus.rd_ready_i = 1'b1;
        for (int w = 0; w < 3; w++) begin
            bus.rd_data_i = 32'hF00 + 32'(w);
            step();
        end
        bus.rd_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        step();
        rst = 1'b0;
        bus.rd_ready_i = 1'b1; bus.rd_owner_i = 2'd1; bus.rd_data_i = 32'h77777777;
        step();
        chk("stale ret err", 64'(bus.err_o), 64'd1);
        chk("stale ret ready", 64'(bus.c_rd_ready_o), 64'(4'b0010));
        bus.rd_ready_i = 1'b0;
        bus.c_rd_req_i = 4'b0010; bus.c_rd_block_i = 4'b0000;
        step();
        chk("post reset grant", 64'(bus.c_rd_ack_o), 64'(4'b0010));
        chk("err sticky", 64'(bus.err_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single user port of the DDR memory controller (read and write request queues) between 2**OWNERS client ports.
- Read and write requests are arbitrated independently, round-robin.
- Each read is tagged with the client index as owner. Returned read words are steered back to that client using the owner tag.
- Each client is limited to one outstanding read (single word or whole-row block). This bounds return traffic per client.

Parameters:
- OWNERS, 2: owner tag bits; number of client ports N = 2**OWNERS (4).
- UADDR, 23: user address bits.
- UWIDTH, 32: user data bits.
- UBYTES, 4: byte enables per word.
- BLOCK_WORDS, 256: words returned by a block read (1 kB row).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- c_rd_req_i  in  N  per-client read request; held until acknowledged.
- c_rd_block_i  in  N  per-client block-read qualifier.
- c_rd_addr_i  in  N*UADDR  client read addresses; client i in bits [i*UADDR +: UADDR].
- c_rd_ack_o  out  N  one-cycle read-accept pulse.
- c_rd_ready_o  out  N  returned-word valid, one-hot.
- c_rd_data_o  out  UWIDTH  returned word, shared by all clients.
- c_wr_req_i  in  N  per-client write request; held until acknowledged.
- c_wr_addr_i  in  N*UADDR  client write addresses.
- c_wr_bes_ni  in  N*UBYTES  client byte enables, active-low.
- c_wr_data_i  in  N*UWIDTH  client write data.
- c_wr_ack_o  out  N  one-cycle write-accept pulse.
- rd_req_o  out  1  read request to controller.
- rd_block_o  out  1  block qualifier to controller.
- rd_owner_o  out  OWNERS  owner tag to controller.
- rd_addr_o  out  UADDR  read address to controller.
- rd_busy_i  in  1  controller read queue full.
- rd_owner_i  in  OWNERS  owner tag of returned word.
- rd_data_i  in  UWIDTH  returned word from controller.
- rd_ready_i  in  1  returned word valid.
- wr_req_o  out  1  write request to controller.
- wr_addr_o  out  UADDR  write address to controller.
- wr_bes_no  out  UBYTES  byte enables to controller, active-low.
- wr_data_o  out  UWIDTH  write data to controller.
- wr_busy_i  in  1  controller write queue full.
- err_o  out  1  sticky: word returned for a client with no read pending.

Behaviour:
- All outputs are registered.
- Reset (asynchronous) clears:
  - all req, ack and ready outputs, and err_o;
  - all data, address and tag outputs;
  - all pending flags and word counters;
  - both round-robin pointers, which are set to N-1 so client 0 wins first.
- Read eligibility: client i is eligible when c_rd_req_i[i]=1, pend[i]=0 and c_rd_ack_o[i]=0.
- Read issue: occurs when rd_busy_i=0 and at least one client is eligible.
  - Winner g is the first eligible client searching rdptr+1, rdptr+2, … modulo N.
  - Next edge: rd_req_o=1 for exactly one cycle; rd_addr_o, rd_block_o and rd_owner_o=g are loaded; c_rd_ack_o[g]=1 for one cycle; rdptr=g; pend[g]=1; cnt[g]=BLOCK_WORDS if block, else 1.
  - Otherwise rd_req_o=0. Address, block and owner outputs hold their values.
- Read return: on rd_ready_i=1 with owner o, at the next edge c_rd_ready_o is one-hot at bit o and c_rd_data_o=rd_data_i. Latency is 1 cycle.
  - If pend[o]=1: cnt[o] decrements. When it reaches 0, pend[o] clears; client o becomes eligible the cycle after its last word.
  - If pend[o]=0: err_o is set (sticky until reset), the word is still forwarded, and counters are unchanged.
- Issue and return in the same cycle are independent. A client's own issue and return cannot coincide, because a pending client is never eligible.
- Write eligibility: client i is eligible when c_wr_req_i[i]=1 and c_wr_ack_o[i]=0.
- Write issue: occurs when wr_busy_i=0. It uses a separate pointer wrptr with the same round-robin rule.
  - Next edge: wr_req_o=1 for one cycle; winner's address, byte enables and data are loaded; c_wr_ack_o[g]=1 for one cycle.
  - Writes have no pending state, so back-to-back writes from different clients may issue on consecutive cycles.
- Busy: rd_busy_i/wr_busy_i high blocks new issue on that side only. Requests stay held, and the pointer does not move.
- Counter width: clog2(BLOCK_WORDS+1) bits. No wrap is possible because decrement occurs only while pend=1 (cnt≥1).
- Reset mid-operation: pending state is discarded. Words still in flight from the controller afterwards assert err_o. The system resets the controller together with this block.

Test Plan:
- Single read: client 2 requests (block=0, addr 0x00_1234), rd_busy_i=0 → next cycle rd_req_o=1, rd_owner_o=2, rd_addr_o=0x001234, c_rd_ack_o=4'b0100. Return of 0xDEADBEEF with owner 2 → c_rd_ready_o=4'b0100 one cycle later, and client 2 becomes eligible again.
- Round-robin: all 4 clients hold read requests after reset → grants in order 0,1,2,3 on consecutive cycles. A 5th request from client 0 is not granted until its word returns.
- Block read: client 1 block read → 256 returns keep pend[1]=1; its new request is granted only after the 256th word.
- Busy stall: rd_busy_i=1 for 5 cycles with client 3 requesting → no rd_req_o or ack. First cycle after busy falls → grant to 3.
- Writes: clients 0 and 3 write (bes 4'b0000, data 0x11111111 and 0x33333333) → wr_req_o on two consecutive cycles, data in order client 0 then client 3. wr_busy_i=1 holds both.
- Error and reset: return with owner 1 while nothing is pending → err_o=1, sticky. Assert reset_i mid-block-read → all outputs are 0 immediately and pending state clears.
